// File: rtl/groestl512_iter.sv
// Folded Groestl-512 core for one pre-padded 648-bit block: UNROLL rounds per clock
// per permutation, valid/ready on input and output, tag passthrough.
module groestl512_iter #(
   parameter int unsigned UNROLL = 1,
   parameter int unsigned TAG_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [647:0]     in_block,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [511:0]     out_hash,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);
   localparam int unsigned STATE_W  = 1024;
   localparam int unsigned HASH_W   = 512;
   localparam logic [3:0]  LAST_RND = 4'd14;
   localparam logic [3:0]  RND_STEP = 4'(UNROLL);
   localparam logic [STATE_W-1:0] IV = STATE_W'(16'h0200);
   localparam int SH_P [8] = '{0, 1, 2, 3, 4, 5, 6, 11};
   localparam int SH_Q [8] = '{1, 3, 5, 11, 0, 2, 4, 6};
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 7 || UNROLL == 14)) begin : g_bad_unroll
      $error("groestl512_iter: UNROLL must be 1, 2, 7 or 14");
   end

   typedef enum logic [1:0] {S_IDLE, S_PQ, S_F, S_DONE} state_e;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   // GF(2^8) multiply by the MixBytes circulant coefficient at position idx
   function automatic logic [7:0] mulc(input logic [7:0] x, input int idx);
      logic [7:0] x2, x4;
      x2 = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      x4 = {x2[6:0], 1'b0} ^ (x2[7] ? 8'h1b : 8'h00);
      case (idx)
         0, 1:    return x2;
         2, 5:    return x2 ^ x;
         3:       return x4;
         4, 6:    return x4 ^ x;
         default: return x4 ^ x2 ^ x;
      endcase
   endfunction

   // One round; Q state is held complemented so its constant reduces to a row-7 XOR
   function automatic logic [STATE_W-1:0] grs_round(input logic [STATE_W-1:0] s,
                                                    input logic [3:0] rnd, input logic is_q);
      logic [7:0] a [8][16];
      logic [7:0] b [8][16];
      logic [7:0] acc;
      logic [STATE_W-1:0] o;
      o = '0;
      for (int c = 0; c < 16; c++)
         for (int r = 0; r < 8; r++)
            a[r][c] = s[STATE_W-1-8*(8*c+r) -: 8];
      for (int c = 0; c < 16; c++) begin
         if (is_q) a[7][c] = a[7][c] ^ {4'(c), rnd};
         else      a[0][c] = a[0][c] ^ {4'(c), rnd};
      end
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 16; c++)
            b[r][c] = sbox(a[r][(c + (is_q ? SH_Q[r] : SH_P[r])) % 16]);
      for (int c = 0; c < 16; c++)
         for (int r = 0; r < 8; r++) begin
            acc = '0;
            for (int k = 0; k < 8; k++) acc = acc ^ mulc(b[k][c], (k - r + 8) % 8);
            o[STATE_W-1-8*(8*c+r) -: 8] = acc;
         end
      return is_q ? ~o : o;
   endfunction

   state_e             state_q, state_d;
   logic [3:0]         rnd_q, rnd_d;
   logic [STATE_W-1:0] p_q, p_d, q_q, q_d, p_nx, q_nx, h_new, msg;
   logic [HASH_W-1:0]  hs_q, hs_d, out_hash_q, out_hash_d;
   logic [TAG_W-1:0]   tag_q, tag_d, out_tag_q, out_tag_d;
   logic               out_valid_q, out_valid_d, busy_q, accept;

   assign in_ready  = rst_n && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
   assign accept    = in_valid && in_ready;
   assign msg       = {in_block, 360'd0, 16'h0001};
   assign h_new     = p_q ^ ~q_q ^ IV;
   assign out_valid = out_valid_q;
   assign out_hash  = out_hash_q;
   assign out_tag   = out_tag_q;
   assign busy      = busy_q;

   // Round chain: UNROLL rounds of P and Q starting at rnd_q
   always_comb begin
      p_nx = p_q;
      q_nx = q_q;
      for (int k = 0; k < UNROLL; k++) begin
         p_nx = grs_round(p_nx, rnd_q + 4'(k), 1'b0);
         q_nx = grs_round(q_nx, rnd_q + 4'(k), 1'b1);
      end
   end

   always_comb begin
      state_d     = state_q;
      rnd_d       = rnd_q;
      p_d         = p_q;
      q_d         = q_q;
      hs_d        = hs_q;
      tag_d       = tag_q;
      out_valid_d = out_valid_q;
      out_hash_d  = out_hash_q;
      out_tag_d   = out_tag_q;
      case (state_q)
         S_PQ: begin
            if (rnd_q == LAST_RND) begin
               p_d     = h_new;
               hs_d    = h_new[HASH_W-1:0];
               rnd_d   = '0;
               state_d = S_F;
            end else begin
               p_d   = p_nx;
               q_d   = q_nx;
               rnd_d = rnd_q + RND_STEP;
            end
         end
         S_F: begin
            p_d   = p_nx;
            rnd_d = rnd_q + RND_STEP;
            if (rnd_q + RND_STEP == LAST_RND) begin
               out_hash_d  = p_nx[HASH_W-1:0] ^ hs_q;
               out_tag_d   = tag_q;
               out_valid_d = 1'b1;
               rnd_d       = '0;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Accept is only possible from IDLE or the DONE handoff
      if (accept) begin
         p_d     = msg ^ IV;
         q_d     = ~msg;
         tag_d   = in_tag;
         rnd_d   = '0;
         state_d = S_PQ;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rnd_q       <= '0;
         out_valid_q <= 1'b0;
         out_hash_q  <= '0;
         out_tag_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rnd_q       <= rnd_d;
         out_valid_q <= out_valid_d;
         out_hash_q  <= out_hash_d;
         out_tag_q   <= out_tag_d;
         busy_q      <= (state_d != S_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      p_q   <= p_d;
      q_q   <= q_d;
      hs_q  <= hs_d;
      tag_q <= tag_d;
   end
endmodule

// File: tb/tb_groestl512_iter.sv
// Bench for groestl512_iter: four cores (UNROLL 1/2/7/14) checked against a
// byte-array Groestl-512 model built from the algorithm definition.
`timescale 1ns/1ps
module tb_groestl512_iter;
   localparam int NU = 4;
   localparam int SHP [8] = '{0, 1, 2, 3, 4, 5, 6, 11};
   localparam int SHQ [8] = '{1, 3, 5, 11, 0, 2, 4, 6};
   localparam logic [7:0] MB [8] = '{8'h02, 8'h02, 8'h03, 8'h04, 8'h05, 8'h03, 8'h05, 8'h07};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid  [NU];
   logic         in_ready  [NU];
   logic [647:0] in_block  [NU];
   logic [31:0]  in_tag    [NU];
   logic         out_valid [NU];
   logic         out_ready [NU];
   logic [511:0] out_hash  [NU];
   logic [31:0]  out_tag   [NU];
   logic         busy      [NU];
   logic [7:0]   sbox_m    [256];
   int           n_chk = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NU; g++) begin : g_dut
      groestl512_iter #(.UNROLL((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 7 : 14), .TAG_W(32)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_block(in_block[g]), .in_tag(in_tag[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_hash(out_hash[g]),
         .out_tag(out_tag[g]), .busy(busy[g]));
   end

   function automatic int unroll_of(input int d);
      return (d == 0) ? 1 : (d == 1) ? 2 : (d == 2) ? 7 : 14;
   endfunction

   task automatic chk(input string what, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", what, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = '0; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [1023:0] perm(input logic [1023:0] x, input bit is_q);
      logic [7:0] a [8][16];
      logic [7:0] t [8][16];
      logic [7:0] acc;
      logic [1023:0] y;
      for (int n = 0; n < 128; n++) a[n % 8][n / 8] = x[1023 - 8*n -: 8];
      for (int i = 0; i < 14; i++) begin
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) begin
               if (is_q) a[r][c] = a[r][c] ^ ((r == 7) ? 8'((c << 4) ^ 255 ^ i) : 8'hff);
               else if (r == 0) a[r][c] = a[r][c] ^ 8'((c << 4) ^ i);
               a[r][c] = sbox_m[a[r][c]];
            end
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
               t[r][c] = a[r][(c + (is_q ? SHQ[r] : SHP[r])) % 16];
         for (int c = 0; c < 16; c++)
            for (int r = 0; r < 8; r++) begin
               acc = '0;
               for (int k = 0; k < 8; k++) acc = acc ^ gmul(MB[(k - r + 8) % 8], t[k][c]);
               a[r][c] = acc;
            end
      end
      for (int n = 0; n < 128; n++) y[1023 - 8*n -: 8] = a[n % 8][n / 8];
      return y;
   endfunction

   function automatic logic [511:0] grs_ref(input logic [647:0] blk);
      logic [1023:0] m, iv, h, f;
      m  = {blk, 360'd0, 16'h0001};
      iv = 1024'h200;
      h  = perm(m ^ iv, 1'b0) ^ perm(m, 1'b1) ^ iv;
      f  = perm(h, 1'b0) ^ h;
      return f[511:0];
   endfunction

   function automatic logic [647:0] rand_block();
      logic [647:0] v;
      v = '0;
      for (int i = 0; i < 21; i++) v = {v[615:0], $urandom};
      return v;
   endfunction

   // One job on core d with out_ready high; optional stray in_valid pulse while busy
   task automatic run_job(input int d, input logic [647:0] b, input logic [31:0] t, input bit pulse);
      logic [511:0] exp_h;
      int lat;
      string u;
      u = $sformatf("u%0d", unroll_of(d));
      exp_h = grs_ref(b);
      lat = 0;
      out_ready[d] = 1'b1;
      chk({u, "_in_ready_idle"}, 512'(in_ready[d]), 512'(1));
      in_block[d] = b; in_tag[d] = t; in_valid[d] = 1'b1;
      @(posedge clk); #1;
      in_valid[d] = 1'b0; in_block[d] = ~b; in_tag[d] = ~t;
      chk({u, "_busy_after_accept"}, 512'(busy[d]), 512'(1));
      chk({u, "_in_ready_busy"}, 512'(in_ready[d]), 512'(0));
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk); #1;
         if (out_valid[d]) begin
            lat = e;
            break;
         end
         if (pulse) in_valid[d] = (e == 2);
      end
      in_valid[d] = 1'b0;
      chk({u, "_latency"}, 512'(lat), 512'(2 * (14 / unroll_of(d)) + 1));
      chk({u, "_hash"}, out_hash[d], exp_h);
      chk({u, "_tag"}, 512'(out_tag[d]), 512'(t));
      @(posedge clk); #1;
      chk({u, "_valid_drop"}, 512'(out_valid[d]), 512'(0));
      chk({u, "_busy_idle"}, 512'(busy[d]), 512'(0));
      chk({u, "_in_ready_back"}, 512'(in_ready[d]), 512'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [647:0] rb;
      logic [31:0]  t;
      logic [511:0] eh;
      logic [7:0]   inv, sb;
      logic [647:0] jb [4];
      logic [31:0]  jt [4];
      logic [511:0] jh [4];
      int           acc_e [4];
      int           out_e [4];
      int           ni, no, lat, seen;
      bit           acc;

      for (int x = 0; x < 256; x++) begin
         inv = '0;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
              {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox_m[x] = sb;
      end

      rst_n = 1'b0;
      for (int d = 0; d < NU; d++) begin
         in_valid[d] = 1'b0; out_ready[d] = 1'b1; in_block[d] = '0; in_tag[d] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < NU; d++) begin
         chk($sformatf("u%0d_rst_out_valid", unroll_of(d)), 512'(out_valid[d]), 512'(0));
         chk($sformatf("u%0d_rst_busy", unroll_of(d)), 512'(busy[d]), 512'(0));
         chk($sformatf("u%0d_rst_in_ready", unroll_of(d)), 512'(in_ready[d]), 512'(0));
         chk($sformatf("u%0d_rst_hash", unroll_of(d)), out_hash[d], 512'(0));
         chk($sformatf("u%0d_rst_tag", unroll_of(d)), 512'(out_tag[d]), 512'(0));
      end
      rst_n = 1'b1;
      #1;

      run_job(0, '0, 32'h0000005A, 1'b0);

      rb = rand_block();
      for (int d = 0; d < NU; d++) run_job(d, rb, $urandom, d == 0);

      // Back-pressure on UNROLL=7 with a stray offer while blocked
      rb = rand_block(); t = 32'hB0B00001; eh = grs_ref(rb);
      out_ready[2] = 1'b0; in_block[2] = rb; in_tag[2] = t; in_valid[2] = 1'b1;
      @(posedge clk); #1;
      in_valid[2] = 1'b0;
      lat = 0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         if (out_valid[2]) begin
            lat = e;
            break;
         end
      end
      chk("bp_latency", 512'(lat), 512'(5));
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            in_valid[2] = 1'b1; in_tag[2] = ~t; in_block[2] = ~rb;
         end
         @(posedge clk); #1;
         chk("bp_valid_hold", 512'(out_valid[2]), 512'(1));
         chk("bp_hash_hold", out_hash[2], eh);
         chk("bp_tag_hold", 512'(out_tag[2]), 512'(t));
         chk("bp_in_ready_low", 512'(in_ready[2]), 512'(0));
      end
      in_valid[2] = 1'b0;
      out_ready[2] = 1'b1;
      #1;
      chk("bp_in_ready_release", 512'(in_ready[2]), 512'(1));
      @(posedge clk); #1;
      chk("bp_valid_drop", 512'(out_valid[2]), 512'(0));
      chk("bp_in_ready_idle", 512'(in_ready[2]), 512'(1));

      // Back-to-back jobs on UNROLL=2
      for (int i = 0; i < 4; i++) begin
         jb[i] = rand_block(); jt[i] = 32'hC0DE0000 + 32'(i); jh[i] = grs_ref(jb[i]);
         acc_e[i] = 0; out_e[i] = 0;
      end
      ni = 0; no = 0;
      in_block[1] = jb[0]; in_tag[1] = jt[0]; in_valid[1] = 1'b1;
      for (int e = 1; e <= 120 && no < 4; e++) begin
         acc = in_valid[1] && in_ready[1];
         @(posedge clk); #1;
         if (acc && ni < 4) begin
            acc_e[ni] = e;
            ni++;
            if (ni < 4) begin
               in_block[1] = jb[ni]; in_tag[1] = jt[ni];
            end else in_valid[1] = 1'b0;
         end
         if (out_valid[1]) begin
            out_e[no] = e;
            chk($sformatf("b2b_tag%0d", no), 512'(out_tag[1]), 512'(jt[no]));
            chk($sformatf("b2b_hash%0d", no), out_hash[1], jh[no]);
            no++;
         end
      end
      in_valid[1] = 1'b0;
      chk("b2b_results", 512'(no), 512'(4));
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("b2b_latency%0d", i), 512'(out_e[i] - acc_e[i]), 512'(15));
         if (i > 0) chk($sformatf("b2b_handoff%0d", i), 512'(acc_e[i]), 512'(out_e[i-1] + 1));
      end
      @(posedge clk); #1;

      // Reset in the middle of an UNROLL=1 job
      rb = rand_block();
      in_block[0] = rb; in_tag[0] = 32'hDEAD0007; in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_busy", 512'(busy[0]), 512'(0));
      chk("mid_rst_in_ready_low", 512'(in_ready[0]), 512'(0));
      rst_n = 1'b1;
      #1;
      chk("mid_rst_busy_after", 512'(busy[0]), 512'(0));
      chk("mid_rst_in_ready_after", 512'(in_ready[0]), 512'(1));
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid[0]) seen++;
      end
      chk("mid_rst_no_result", 512'(seen), 512'(0));
      run_job(0, rand_block(), 32'h12345678, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
